// File: rtl/uart_rx_deframer.sv
`timescale 1ns/1ps
// uart_rx_deframer
//   UART receive engine. Synchronises and oversamples the rx line (8 ticks per
//   bit, tick every prescaler+1 PCLKs), deframes 5..9 data bits with optional
//   parity and 1 or 2 stop bits, and presents each word on a valid/ready port.
// Ports
//   PCLK, PRESETn    clock, synchronous active-low reset
//   en               receiver enable (0 aborts the frame in progress)
//   prescaler        baud tick divisor
//   data_size        data bits 5..9 (other codes -> 8)
//   parity           000 none, 001 odd, 010 even, 100 stick-0, 101 stick-1
//   stop2            1 = two stop bits
//   rx               asynchronous serial input, idle high
//   rdata/rvalid     received word and valid, held until rready
//   rready           consumer accept
//   overrun, frame_err, parity_err, brk   single-cycle status pulses
//   busy             receiver not idle
module uart_rx_deframer #(
    parameter int PR_W    = 16,
    parameter int SYNC_FF = 2
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            en,
    input  logic [PR_W-1:0] prescaler,
    input  logic [3:0]      data_size,
    input  logic [2:0]      parity,
    input  logic            stop2,
    input  logic            rx,
    output logic [8:0]      rdata,
    output logic            rvalid,
    input  logic            rready,
    output logic            overrun,
    output logic            frame_err,
    output logic            parity_err,
    output logic            brk,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
    } state_t;

    state_t state, state_n;

    logic [SYNC_FF-1:0] sync_q;
    logic               rx_s;
    logic               rx_prev;
    logic [PR_W-1:0]    presc_q;
    logic [PR_W-1:0]    presc_cnt;
    logic [2:0]         sub_cnt;
    logic [3:0]         bit_cnt;
    logic [3:0]         nbits_q;
    logic [3:0]         nbits_in;
    logic [2:0]         par_q;
    logic               stop2_q;
    logic [8:0]         word_q;
    logic               par_bit_q;
    logic               stop_bad_q;
    logic               any_one_q;
    logic               start_det;
    logic               tick;
    logic               samp;
    logic               par_en;
    logic               par_exp;
    logic               is_brk;

    assign rx_s      = sync_q[SYNC_FF-1];
    assign start_det = (state == S_IDLE) && en && rx_prev && !rx_s;
    assign tick      = (state != S_IDLE) && (presc_cnt == presc_q);
    // Start bit is checked 4 ticks in (mid-bit); every later sample is 8 ticks apart.
    assign samp      = tick && ((state == S_START) ? (sub_cnt == 3'd3) : (sub_cnt == 3'd7));
    assign par_en    = (par_q == 3'b001) || (par_q == 3'b010) ||
                       (par_q == 3'b100) || (par_q == 3'b101);
    assign is_brk    = !any_one_q;
    assign busy      = (state != S_IDLE);

    always_comb begin
        nbits_in = 4'd8;
        if (data_size >= 4'd5 && data_size <= 4'd9) nbits_in = data_size;
    end

    always_comb begin
        par_exp = 1'b0;
        case (par_q)
            3'b001:  par_exp = ~(^word_q);
            3'b010:  par_exp = ^word_q;
            3'b101:  par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!en) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start_det) state_n = S_START;
                S_START:  if (samp) state_n = rx_s ? S_IDLE : S_DATA;
                S_DATA:   if (samp && (bit_cnt == nbits_q - 4'd1))
                              state_n = par_en ? S_PARITY : S_STOP1;
                S_PARITY: if (samp) state_n = S_STOP1;
                S_STOP1:  if (samp) state_n = stop2_q ? S_STOP2 : S_DONE;
                S_STOP2:  if (samp) state_n = S_DONE;
                S_DONE:   state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            sync_q     <= '1;
            rx_prev    <= 1'b1;
            presc_q    <= '0;
            presc_cnt  <= '0;
            sub_cnt    <= '0;
            bit_cnt    <= '0;
            nbits_q    <= '0;
            par_q      <= '0;
            stop2_q    <= 1'b0;
            word_q     <= '0;
            par_bit_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            any_one_q  <= 1'b0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_FF-2:0], rx};
            rx_prev    <= rx_s;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;

            if (state == S_IDLE)  presc_cnt <= '0;
            else if (tick)        presc_cnt <= '0;
            else                  presc_cnt <= presc_cnt + 1'b1;

            if (state == S_IDLE)                 sub_cnt <= '0;
            else if (samp && state == S_START)   sub_cnt <= '0;
            else if (tick)                       sub_cnt <= sub_cnt + 3'd1;

            if (start_det) begin
                presc_q    <= prescaler;
                nbits_q    <= nbits_in;
                par_q      <= parity;
                stop2_q    <= stop2;
                word_q     <= '0;
                bit_cnt    <= '0;
                par_bit_q  <= 1'b0;
                stop_bad_q <= 1'b0;
                any_one_q  <= 1'b0;
            end

            if (samp) begin
                case (state)
                    S_DATA: begin
                        word_q[bit_cnt] <= rx_s;
                        bit_cnt         <= bit_cnt + 4'd1;
                        any_one_q       <= any_one_q | rx_s;
                    end
                    S_PARITY: begin
                        par_bit_q <= rx_s;
                        any_one_q <= any_one_q | rx_s;
                    end
                    S_STOP1, S_STOP2: begin
                        if (!rx_s) stop_bad_q <= 1'b1;
                        any_one_q <= any_one_q | rx_s;
                    end
                    default: ;
                endcase
            end

            if (rvalid && rready) rvalid <= 1'b0;

            if (state == S_DONE) begin
                if (is_brk) begin
                    brk <= 1'b1;
                end else begin
                    frame_err  <= stop_bad_q;
                    parity_err <= par_en && (par_bit_q != par_exp);
                    if (!rvalid || rready) begin
                        rdata  <= word_q;
                        rvalid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
module tb_uart_rx_deframer;

    logic        PCLK;
    logic        PRESETn;
    logic        en;
    logic [15:0] prescaler;
    logic [3:0]  data_size;
    logic [2:0]  parity;
    logic        stop2;
    logic        rx;
    logic [8:0]  rdata;
    logic        rvalid;
    logic        rready;
    logic        overrun;
    logic        frame_err;
    logic        parity_err;
    logic        brk;
    logic        busy;

    uart_rx_deframer #(.PR_W(16), .SYNC_FF(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .prescaler(prescaler),
        .data_size(data_size), .parity(parity), .stop2(stop2), .rx(rx),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .overrun(overrun),
        .frame_err(frame_err), .parity_err(parity_err), .brk(brk), .busy(busy)
    );

    initial PCLK = 1'b0;
    always #50 PCLK = ~PCLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Event monitor: accepted words and pulse counts, sampled mid-cycle.
    logic [8:0] words[$];
    int n_ovr = 0, n_fe = 0, n_pe = 0, n_brk = 0, n_vcyc = 0;
    always @(negedge PCLK) begin
        if (rvalid) n_vcyc++;
        if (rvalid && rready) words.push_back(rdata);
        if (overrun)    n_ovr++;
        if (frame_err)  n_fe++;
        if (parity_err) n_pe++;
        if (brk)        n_brk++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] last_word();
        if (words.size() == 0) return 9'bx;
        return words[words.size()-1];
    endfunction

    task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                              input logic pbit, input int nstop, input logic sval,
                              input int bit_ns);
        rx = 1'b0; #(bit_ns);
        for (int i = 0; i < nb; i++) begin rx = d[i]; #(bit_ns); end
        if (has_par) begin rx = pbit; #(bit_ns); end
        for (int i = 0; i < nstop; i++) begin rx = sval; #(bit_ns); end
        rx = 1'b1; #(2 * bit_ns);
        @(negedge PCLK);
    endtask

    // Start bit plus the first three data bits of 0x5A, leaving the DUT mid-DATA.
    task automatic partial_5a(input int bit_ns);
        rx = 1'b0; #(bit_ns);
        rx = 1'b0; #(bit_ns);
        rx = 1'b1; #(bit_ns);
        rx = 1'b0; #(bit_ns / 2);
        @(negedge PCLK);
    endtask

    int w0, o0, f0, p0, b0, v0;
    task automatic snap();
        w0 = words.size(); o0 = n_ovr; f0 = n_fe; p0 = n_pe; b0 = n_brk; v0 = n_vcyc;
    endtask

    localparam int B10 = 8800;
    localparam int B21 = 17600;

    initial begin
        PRESETn = 1'b0; en = 1'b1; prescaler = 16'd10; data_size = 4'd8;
        parity = 3'b000; stop2 = 1'b0; rx = 1'b1; rready = 1'b1;
        repeat (4) @(negedge PCLK);
        check("reset_rdata",  {23'd0, rdata}, 32'h0);
        check("reset_rvalid", {31'd0, rvalid}, 32'h0);
        check("reset_busy",   {31'd0, busy}, 32'h0);
        check("reset_pulses", {28'd0, overrun, frame_err, parity_err, brk}, 32'h0);
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);

        // 1: 8N1 0xA5 at 115200-ish bit time
        snap();
        send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 8680);
        check("t1_count", words.size() - w0, 1);
        check("t1_word",  {23'd0, last_word()}, 32'h0A5);
        check("t1_vcyc",  n_vcyc - v0, 1);
        check("t1_errs",  (n_fe - f0) + (n_pe - p0) + (n_ovr - o0) + (n_brk - b0), 0);
        check("t1_rvalid_low", {31'd0, rvalid}, 32'h0);

        // 2: 8 data, stick-1 parity, 2 stop bits
        prescaler = 16'd21; parity = 3'b101; stop2 = 1'b1;
        snap();
        send_frame(9'h0C3, 8, 1, 1'b1, 2, 1'b1, B21);
        send_frame(9'h091, 8, 1, 1'b1, 2, 1'b1, B21);
        check("t2_count", words.size() - w0, 2);
        check("t2_word0", {23'd0, words[w0]}, 32'h0C3);
        check("t2_word1", {23'd0, words[w0+1]}, 32'h091);
        check("t2_pe_none", n_pe - p0, 0);
        check("t2_fe_none", n_fe - f0, 0);
        send_frame(9'h07E, 8, 1, 1'b0, 2, 1'b1, B21);
        check("t2_pe_pulse", n_pe - p0, 1);
        check("t2_pe_word",  {23'd0, last_word()}, 32'h07E);
        check("t2_pe_count", words.size() - w0, 3);

        // 3: overrun with rready held low
        prescaler = 16'd10; parity = 3'b000; stop2 = 1'b0; rready = 1'b0;
        snap();
        send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1, B10);
        check("t3_first_valid", {31'd0, rvalid}, 32'h1);
        check("t3_first_data",  {23'd0, rdata}, 32'h011);
        send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1, B10);
        check("t3_kept_data", {23'd0, rdata}, 32'h011);
        check("t3_ovr_once",  n_ovr - o0, 1);
        check("t3_no_accept", words.size() - w0, 0);
        rready = 1'b1;
        repeat (3) @(negedge PCLK);
        check("t3_accept_word", {23'd0, last_word()}, 32'h011);
        check("t3_accept_cnt",  words.size() - w0, 1);
        check("t3_rvalid_drop", {31'd0, rvalid}, 32'h0);

        // 4: 300 ns glitch on rx
        snap();
        rx = 1'b0; #300; rx = 1'b1; #200;
        @(negedge PCLK);
        check("t4_busy_during", {31'd0, busy}, 32'h1);
        #(2 * B10); @(negedge PCLK);
        check("t4_busy_after", {31'd0, busy}, 32'h0);
        check("t4_no_word",    words.size() - w0, 0);
        check("t4_no_pulse",   (n_fe - f0) + (n_pe - p0) + (n_ovr - o0) + (n_brk - b0), 0);

        // 5: break, then rx held low
        snap();
        rx = 1'b0; #(12 * B10); @(negedge PCLK);
        check("t5_brk",     n_brk - b0, 1);
        check("t5_no_fe",   n_fe - f0, 0);
        check("t5_no_word", words.size() - w0, 0);
        check("t5_no_restart", {31'd0, busy}, 32'h0);
        #(3 * B10); @(negedge PCLK);
        check("t5_still_idle", {31'd0, busy}, 32'h0);
        rx = 1'b1; #(2 * B10); @(negedge PCLK);
        check("t5_idle_high", {31'd0, busy}, 32'h0);

        // 6a: reset mid-DATA, then clean frame
        partial_5a(B10);
        check("t6_busy_mid", {31'd0, busy}, 32'h1);
        PRESETn = 1'b0; rx = 1'b1;
        repeat (2) @(negedge PCLK);
        check("t6_rst_busy",  {31'd0, busy}, 32'h0);
        check("t6_rst_rdata", {23'd0, rdata}, 32'h0);
        PRESETn = 1'b1;
        #(12 * B10); @(negedge PCLK);
        snap();
        send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, B10);
        check("t6_count", words.size() - w0, 1);
        check("t6_word",  {23'd0, last_word()}, 32'h03C);

        // 6b: en dropped mid-DATA
        partial_5a(B10);
        en = 1'b0;
        @(negedge PCLK);
        check("t6_en_idle", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        #(12 * B10); en = 1'b1; #(B10); @(negedge PCLK);
        snap();
        send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, B10);
        check("t6_en_count", words.size() - w0, 1);
        check("t6_en_word",  {23'd0, last_word()}, 32'h03C);
        check("t6_en_errs",  (n_fe - f0) + (n_brk - b0), 0);

        // Word-size boundaries and a bad stop bit
        data_size = 4'd9;
        snap();
        send_frame(9'h1A5, 9, 0, 1'b0, 1, 1'b1, B10);
        check("t7_9bit", {23'd0, last_word()}, 32'h1A5);
        data_size = 4'd5;
        send_frame(9'h015, 5, 0, 1'b0, 1, 1'b1, B10);
        check("t7_5bit", {23'd0, last_word()}, 32'h015);
        data_size = 4'd8;
        send_frame(9'h055, 8, 0, 1'b0, 1, 1'b0, B10);
        check("t7_fe_pulse", n_fe - f0, 1);
        check("t7_fe_word",  {23'd0, last_word()}, 32'h055);
        check("t7_count",    words.size() - w0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
